// File: rtl/ddr_wr_packer_if.sv
// Byte-stream input and 64-bit DDR write-word output of ddr_wr_packer.
// master = the packer, slave = the stream source / DDR write master side.
interface ddr_wr_packer_if;
  logic [7:0]  data_i;
  logic        data_valid_i;
  logic        sop_i;
  logic        eop_i;
  logic        sof_i;
  logic        eof_i;
  logic [63:0] ddr_wr_data;
  logic [7:0]  ddr_wr_byteen;
  logic        ddr_wr_sof;
  logic        ddr_wr_eof;
  logic        ddr_wr_valid;
  logic        ddr_wr_ready;

  modport master (
    input  data_i, data_valid_i, sop_i, eop_i, sof_i, eof_i, ddr_wr_ready,
    output ddr_wr_data, ddr_wr_byteen, ddr_wr_sof, ddr_wr_eof, ddr_wr_valid
  );

  modport slave (
    output data_i, data_valid_i, sop_i, eop_i, sof_i, eof_i, ddr_wr_ready,
    input  ddr_wr_data, ddr_wr_byteen, ddr_wr_sof, ddr_wr_eof, ddr_wr_valid
  );
endinterface

// File: rtl/ddr_wr_packer.sv
// Packs the deconv byte stream into 64-bit DDR words with per-word sof/eof and byte enables.
// Optional: define DDR_WR_PACKER_BIG_ENDIAN_EN to place the first byte in the word MSB.
module ddr_wr_packer #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned FIFO_DEPTH   = 64,
  parameter int unsigned AFULL_MARGIN = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  ddr_wr_packer_if.master bus,
  output logic            fifo_afull_o,
  output logic            overflow_o,
  output logic            frame_err_o,
  output logic [15:0]     frame_words_o
);
  localparam int unsigned WORD_W = 64;
  localparam int unsigned LANES  = WORD_W / DATA_WIDTH;
  localparam int unsigned LW     = $clog2(LANES);
  localparam int unsigned PW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CW     = PW + 1;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [LANES-1:0]  byteen;
    logic              sof;
    logic              eof;
  } word_t;

  word_t          asm_q, asm_d, cur_w, nw;
  logic [LW-1:0]  lane_q, lane_d, cur_lane;
  logic           pend_q, pend_d;
  logic           push_vld_q, push_vld_d;
  word_t          push_q, push_d;
  logic           ferr_q, ferr_d;

  word_t          mem [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q, count_d;
  logic           valid_q, afull_q, ovf_q;
  logic [15:0]    fcnt_q, fcnt_d, fwords_q, fwords_d;
  word_t          wr_word, rd_word;
  logic           full, rd_en, wr_en;

  // Line markers carry no packing information.
  logic unused_line_marks;
  assign unused_line_marks = bus.sop_i ^ bus.eop_i;

  function automatic word_t map_endian(input word_t w);
    word_t r;
    r = w;
`ifdef DDR_WR_PACKER_BIG_ENDIAN_EN
    for (int unsigned k = 0; k < LANES; k++) begin
      r.data[WORD_W-1-DATA_WIDTH*k -: DATA_WIDTH] = w.data[DATA_WIDTH*k +: DATA_WIDTH];
      r.byteen[LANES-1-k]                         = w.byteen[k];
    end
`endif
    return r;
  endfunction

  // Assembly: a pending word (left by an sof flush) owns the push slot this cycle,
  // so any byte completing now is parked as the next pending word.
  always_comb begin
    cur_w      = asm_q;
    cur_lane   = lane_q;
    nw         = asm_q;
    asm_d      = asm_q;
    lane_d     = lane_q;
    pend_d     = 1'b0;
    push_vld_d = 1'b0;
    push_d     = asm_q;
    ferr_d     = ferr_q;
    if (pend_q) begin
      push_vld_d = 1'b1;
      push_d     = asm_q;
      cur_w      = '0;
      cur_lane   = '0;
    end
    asm_d  = cur_w;
    lane_d = cur_lane;
    if (bus.data_valid_i) begin
      if (bus.sof_i && (cur_lane != '0)) begin
        push_vld_d     = 1'b1;
        push_d         = cur_w;
        push_d.eof     = 1'b0;
        ferr_d         = 1'b1;
        nw             = '0;
        nw.data[DATA_WIDTH-1:0] = bus.data_i;
        nw.byteen[0]   = 1'b1;
        nw.sof         = 1'b1;
        nw.eof         = bus.eof_i;
        asm_d          = nw;
        lane_d         = bus.eof_i ? LW'(0) : LW'(1);
        pend_d         = bus.eof_i;
      end else begin
        nw = cur_w;
        nw.data[DATA_WIDTH*cur_lane +: DATA_WIDTH] = bus.data_i;
        nw.byteen[cur_lane] = 1'b1;
        nw.sof = cur_w.sof | bus.sof_i;
        nw.eof = bus.eof_i;
        if (bus.eof_i || (cur_lane == LW'(LANES-1))) begin
          lane_d = '0;
          if (push_vld_d) begin
            pend_d = 1'b1;
            asm_d  = nw;
          end else begin
            push_vld_d = 1'b1;
            push_d     = nw;
            asm_d      = '0;
          end
        end else begin
          asm_d  = nw;
          lane_d = cur_lane + LW'(1);
        end
      end
    end
  end

  assign wr_word = map_endian(push_q);
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign rd_en   = valid_q & bus.ddr_wr_ready;
  assign wr_en   = push_vld_q & (~full | rd_en);
  assign count_d = count_q + CW'(wr_en) - CW'(rd_en);

  // Frame word counter restarts on the word carrying sof, latches on the eof word.
  always_comb begin
    fcnt_d   = fcnt_q;
    fwords_d = fwords_q;
    if (wr_en) begin
      fcnt_d = wr_word.sof ? 16'd1 : fcnt_q + 16'd1;
      if (wr_word.eof) fwords_d = fcnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      asm_q      <= '0;
      lane_q     <= '0;
      pend_q     <= 1'b0;
      push_vld_q <= 1'b0;
      push_q     <= '0;
      ferr_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      afull_q    <= 1'b0;
      ovf_q      <= 1'b0;
      fcnt_q     <= '0;
      fwords_q   <= '0;
    end else begin
      asm_q      <= asm_d;
      lane_q     <= lane_d;
      pend_q     <= pend_d;
      push_vld_q <= push_vld_d;
      push_q     <= push_d;
      ferr_q     <= ferr_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q    <= count_d;
      valid_q    <= (count_d != '0);
      afull_q    <= (count_q >= CW'(FIFO_DEPTH - AFULL_MARGIN));
      if (push_vld_q && !wr_en) ovf_q <= 1'b1;
      fcnt_q     <= fcnt_d;
      fwords_q   <= fwords_d;
    end
  end

  // Word storage needs no reset; outputs are gated by valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= wr_word;
  end

  assign rd_word           = mem[rd_ptr_q];
  assign bus.ddr_wr_valid  = valid_q;
  assign bus.ddr_wr_data   = valid_q ? rd_word.data   : '0;
  assign bus.ddr_wr_byteen = valid_q ? rd_word.byteen : '0;
  assign bus.ddr_wr_sof    = valid_q & rd_word.sof;
  assign bus.ddr_wr_eof    = valid_q & rd_word.eof;
  assign fifo_afull_o      = afull_q;
  assign overflow_o        = ovf_q;
  assign frame_err_o       = ferr_q;
  assign frame_words_o     = fwords_q;
endmodule

// File: tb/tb_ddr_wr_packer.sv
// Scoreboard bench for ddr_wr_packer: a byte-level packing model queues expected words,
// the output side pops and compares them on every accepted transfer.
`timescale 1ns/1ps
module tb_ddr_wr_packer;
  typedef struct {
    logic [63:0] data;
    logic [7:0]  be;
    logic        sof;
    logic        eof;
  } exp_t;

`ifdef DDR_WR_PACKER_BIG_ENDIAN_EN
  localparam logic [63:0] W_FULL = 64'h0102030405060708;
  localparam logic [63:0] W_TAIL = 64'h18191A0000000000;
  localparam logic [7:0]  BE_TAIL = 8'hE0;
`else
  localparam logic [63:0] W_FULL = 64'h0807060504030201;
  localparam logic [63:0] W_TAIL = 64'h00000000001A1918;
  localparam logic [7:0]  BE_TAIL = 8'h07;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        fifo_afull_o, overflow_o, frame_err_o;
  logic [15:0] frame_words_o;

  ddr_wr_packer_if bus ();

  ddr_wr_packer #(.DATA_WIDTH(8), .FIFO_DEPTH(64), .AFULL_MARGIN(4)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .bus           (bus),
    .fifo_afull_o  (fifo_afull_o),
    .overflow_o    (overflow_o),
    .frame_err_o   (frame_err_o),
    .frame_words_o (frame_words_o)
  );

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          ready_mode = 0;
  bit          stim_done = 1'b0;
  logic [63:0] m_data;
  logic [7:0]  m_be;
  logic        m_sof;
  int          m_lane;
  logic [63:0] last_data;
  logic [7:0]  last_be;
  logic        last_eof;

  always #5 clk = ~clk;

  // Ready: 0 = held low, 1 = held high, otherwise random 50%.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       bus.ddr_wr_ready = 1'b0;
      1:       bus.ddr_wr_ready = 1'b1;
      default: bus.ddr_wr_ready = 1'($urandom_range(0, 1));
    endcase
  end

  function automatic void model_clear();
    m_data = '0; m_be = '0; m_sof = 1'b0; m_lane = 0;
  endfunction

  function automatic void push_exp(input logic [63:0] d, input logic [7:0] be,
                                   input logic s, input logic e);
    exp_t x;
    x.data = d; x.be = be; x.sof = s; x.eof = e;
`ifdef DDR_WR_PACKER_BIG_ENDIAN_EN
    for (int k = 0; k < 8; k++) begin
      x.data[63-8*k -: 8] = d[8*k +: 8];
      x.be[7-k]           = be[k];
    end
`endif
    exp_q.push_back(x);
  endfunction

  task automatic send_byte(input logic [7:0] d, input logic s, input logic e);
    if (s && m_lane != 0) begin
      push_exp(m_data, m_be, m_sof, 1'b0);
      model_clear();
    end
    m_data[m_lane*8 +: 8] = d;
    m_be[m_lane] = 1'b1;
    m_sof = m_sof | s;
    if (e || m_lane == 7) begin
      push_exp(m_data, m_be, m_sof, e);
      model_clear();
    end else begin
      m_lane++;
    end
    bus.data_i = d; bus.data_valid_i = 1'b1;
    bus.sof_i = s; bus.eof_i = e; bus.sop_i = s; bus.eop_i = e;
    @(posedge clk); #1;
    bus.data_valid_i = 1'b0;
    bus.sof_i = 1'b0; bus.eof_i = 1'b0; bus.sop_i = 1'b0; bus.eop_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic monitor(input int budget);
    int   cyc;
    exp_t x;
    cyc = 0;
    while (!(stim_done && exp_q.size() == 0) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (bus.ddr_wr_valid === 1'b1 && bus.ddr_wr_ready === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_word: got data=%h be=%h, required no word",
                   bus.ddr_wr_data, bus.ddr_wr_byteen);
        end else begin
          x = exp_q.pop_front();
          if ({bus.ddr_wr_data, bus.ddr_wr_byteen, bus.ddr_wr_sof, bus.ddr_wr_eof}
              !== {x.data, x.be, x.sof, x.eof}) begin
            bad++;
            $display("FAIL word: got data=%h be=%h sof=%b eof=%b, required data=%h be=%h sof=%b eof=%b",
                     bus.ddr_wr_data, bus.ddr_wr_byteen, bus.ddr_wr_sof, bus.ddr_wr_eof,
                     x.data, x.be, x.sof, x.eof);
          end
          last_data = bus.ddr_wr_data; last_be = bus.ddr_wr_byteen; last_eof = bus.ddr_wr_eof;
        end
      end
    end
    if (!(stim_done && exp_q.size() == 0)) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d words pending, required 0", exp_q.size());
    end
  endtask

  task automatic check_all_zero(input string name);
    total++;
    if ({bus.ddr_wr_valid, bus.ddr_wr_data, bus.ddr_wr_byteen, bus.ddr_wr_sof, bus.ddr_wr_eof,
         fifo_afull_o, overflow_o, frame_err_o, frame_words_o} !== '0) begin
      bad++;
      $display("FAIL %s: got valid=%b data=%h be=%h afull=%b ovf=%b ferr=%b fwords=%0d, required all 0",
               name, bus.ddr_wr_valid, bus.ddr_wr_data, bus.ddr_wr_byteen, fifo_afull_o,
               overflow_o, frame_err_o, frame_words_o);
    end
  endtask

  task automatic test_reset();
    check_all_zero("reset_outputs");
    reset_n = 1'b1;
    idle(3);
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_single_frame();
    ready_mode = 1;
    idle(2);
    stim_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send_byte(8'(i + 1), i == 0, i == 7);
        total++;
        if (bus.ddr_wr_valid !== 1'b0) begin
          bad++; $display("FAIL latency_early: got valid=%b, required 0", bus.ddr_wr_valid);
        end
        idle(1);
        total++;
        if (bus.ddr_wr_valid !== 1'b1 || bus.ddr_wr_data !== W_FULL || bus.ddr_wr_byteen !== 8'hFF) begin
          bad++;
          $display("FAIL latency_word: got valid=%b data=%h be=%h, required 1 %h ff",
                   bus.ddr_wr_valid, bus.ddr_wr_data, bus.ddr_wr_byteen, W_FULL);
        end
        stim_done = 1'b1;
      end
      monitor(200);
    join
    idle(2);
    total++;
    if (frame_words_o !== 16'd1) begin
      bad++; $display("FAIL frame_words_1: got %0d, required 1", frame_words_o);
    end
  endtask

  task automatic test_partial_frame();
    stim_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 11; i++) send_byte(8'(8'h10 + i), i == 0, i == 10);
        stim_done = 1'b1;
      end
      monitor(200);
    join
    idle(2);
    total++;
    if (last_data !== W_TAIL || last_be !== BE_TAIL || last_eof !== 1'b1) begin
      bad++;
      $display("FAIL tail_word: got data=%h be=%h eof=%b, required %h %h 1",
               last_data, last_be, last_eof, W_TAIL, BE_TAIL);
    end
    total++;
    if (frame_words_o !== 16'd2) begin
      bad++; $display("FAIL frame_words_2: got %0d, required 2", frame_words_o);
    end
  endtask

  task automatic test_long_frame();
    ready_mode = 2;
    stim_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 672; i++) send_byte(8'(i * 7 + 3), i == 0, i == 671);
        stim_done = 1'b1;
      end
      monitor(5000);
    join
    idle(3);
    total++;
    if (frame_words_o !== 16'd84 || overflow_o !== 1'b0) begin
      bad++;
      $display("FAIL long_frame: got fwords=%0d ovf=%b, required 84 0", frame_words_o, overflow_o);
    end
  endtask

  task automatic test_overflow();
    ready_mode = 0;
    idle(2);
    stim_done = 1'b0;
    fork
      begin
        for (int w = 0; w < 70; w++) begin
          for (int k = 0; k < 8; k++) send_byte((k == 0) ? 8'(w) : 8'(8'hA0 + k), 1'b0, 1'b0);
          if (w == 58 || w == 59 || w == 63 || w == 64) begin
            idle(3);
            total++;
            if ((w == 58 && fifo_afull_o !== 1'b0) || (w == 59 && fifo_afull_o !== 1'b1) ||
                (w == 63 && (overflow_o !== 1'b0 || fifo_afull_o !== 1'b1)) ||
                (w == 64 && overflow_o !== 1'b1)) begin
              bad++;
              $display("FAIL fill_word_%0d: got afull=%b ovf=%b", w + 1, fifo_afull_o, overflow_o);
            end
          end
        end
        repeat (6) void'(exp_q.pop_back());
        ready_mode = 1;
        stim_done = 1'b1;
      end
      monitor(3000);
    join
    idle(3);
    total++;
    if (bus.ddr_wr_valid !== 1'b0 || fifo_afull_o !== 1'b0 || overflow_o !== 1'b1) begin
      bad++;
      $display("FAIL after_drain: got valid=%b afull=%b ovf=%b, required 0 0 1",
               bus.ddr_wr_valid, fifo_afull_o, overflow_o);
    end
  endtask

  task automatic test_sof_flush();
    total++;
    if (frame_err_o !== 1'b0) begin
      bad++; $display("FAIL ferr_clean: got %b, required 0", frame_err_o);
    end
    stim_done = 1'b0;
    fork
      begin
        send_byte(8'h21, 1'b1, 1'b0); send_byte(8'h22, 1'b0, 1'b0); send_byte(8'h23, 1'b0, 1'b0);
        send_byte(8'h24, 1'b1, 1'b0); send_byte(8'h25, 1'b0, 1'b0); send_byte(8'h26, 1'b0, 1'b1);
        send_byte(8'h31, 1'b1, 1'b0); send_byte(8'h32, 1'b0, 1'b0);
        send_byte(8'h33, 1'b1, 1'b1); send_byte(8'h34, 1'b1, 1'b1);
        send_byte(8'h35, 1'b1, 1'b0); send_byte(8'h36, 1'b0, 1'b1);
        stim_done = 1'b1;
      end
      monitor(300);
    join
    idle(2);
    total++;
    if (frame_err_o !== 1'b1 || frame_words_o !== 16'd1) begin
      bad++;
      $display("FAIL sof_flush_flags: got ferr=%b fwords=%0d, required 1 1", frame_err_o, frame_words_o);
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) send_byte(8'(8'h50 + i), i == 0, 1'b0);
    reset_n = 1'b0;
    #1;
    check_all_zero("mid_reset_outputs");
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_clear();
    stim_done = 1'b0;
    fork
      begin
        idle(10);
        total++;
        if (bus.ddr_wr_valid !== 1'b0) begin
          bad++; $display("FAIL no_flush_on_reset: got valid=%b, required 0", bus.ddr_wr_valid);
        end
        for (int i = 0; i < 8; i++) send_byte(8'(8'h41 + i), i == 0, i == 7);
        stim_done = 1'b1;
      end
      monitor(300);
    join
    idle(2);
    total++;
    if (frame_words_o !== 16'd1 || frame_err_o !== 1'b0) begin
      bad++;
      $display("FAIL after_reset_frame: got fwords=%0d ferr=%b, required 1 0", frame_words_o, frame_err_o);
    end
  endtask

  initial begin
    bus.data_i = '0; bus.data_valid_i = 1'b0;
    bus.sop_i = 1'b0; bus.eop_i = 1'b0; bus.sof_i = 1'b0; bus.eof_i = 1'b0;
    model_clear();
    last_data = '0; last_be = '0; last_eof = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_single_frame();
    test_partial_frame();
    test_long_frame();
    test_overflow();
    test_sof_flush();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
